// File: rtl/nibble_add_seq.sv
// Multi-cycle adder that time-shares one 4-bit carry slice over WIDTH/4 steps.
// Define NIBBLE_ADD_SEQ_SUB_EN to add the sub port (a + ~b + 1 when sub=1).
module nibble_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef NIBBLE_ADD_SEQ_SUB_EN
  input  logic             sub,
`endif
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             busy
);

  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_d;
  logic             carry_q, cout_q;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [4:0]       slice;
  logic             accept, last_step;
  logic [WIDTH-1:0] b_eff;
  logic             cin_eff;

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  // Subtraction folds into the same adder: invert B once at accept, force carry-in.
  assign b_eff   = sub ? ~b : b;
  assign cin_eff = sub ? 1'b1 : cin;
`else
  assign b_eff   = b;
  assign cin_eff = cin;
`endif

  assign accept    = (state_q == S_IDLE) && in_valid;
  assign last_step = (cnt_q == CW'(N - 1));
  assign a_sh      = a_q >> {cnt_q, 2'b00};
  assign b_sh      = b_q >> {cnt_q, 2'b00};
  assign slice     = {1'b0, a_sh[3:0]} + {1'b0, b_sh[3:0]} + {4'b0000, carry_q};

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_nib
      assign sum_d[4*gi +: 4] = (state_q == S_RUN && cnt_q == CW'(gi))
                                ? slice[3:0] : sum_q[4*gi +: 4];
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (in_valid) state_d = S_RUN;
      S_RUN:   if (last_step) state_d = S_DONE;
      S_DONE:  if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state_q == S_IDLE);
    out_valid = (state_q == S_DONE);
    busy      = (state_q == S_RUN) || (state_q == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else if (accept) begin
      a_q     <= a;
      b_q     <= b_eff;
      carry_q <= cin_eff;
      cnt_q   <= '0;
    end else if (state_q == S_RUN) begin
      sum_q   <= sum_d;
      carry_q <= slice[4];
      cnt_q   <= cnt_q + CW'(1);
      if (last_step) cout_q <= slice[4];
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_add_seq.sv
// Randomized self-checking bench for nibble_add_seq (WIDTH=16) against a plain-arithmetic model.
module tb_nibble_add_seq;
  localparam int W = 16;
  localparam int N = W / 4;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, cin, cout, out_valid, out_ready, busy, sub;
  logic [W-1:0] a, b, sum;
  int           total = 0;
  int           bad   = 0;

  always #5 clk = ~clk;

  nibble_add_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin),
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    .sub(sub),
`endif
    .sum(sum), .cout(cout), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  // Reference: {cout, sum} as a WIDTH+1 bit integer sum.
  function automatic logic [W:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                       input logic c, input logic s);
    logic [W-1:0] ny;
    ny = ~y;
    if (s) return {1'b0, x} + {1'b0, ny} + (W+1)'(1);
    return {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
  endfunction

  // Presents one operand set from IDLE; returns #1 after the accept edge with junk on the operand pins.
  task automatic accept_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic c, input logic s);
    a = x; b = y; cin = c; sub = s; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
  endtask

  task automatic wait_done(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
    a = 16'h1111; b = 16'h2222; cin = 1'b1; sub = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
      total++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
        bad++;
        $display("FAIL reset: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b required 1 0 0 0000 0",
                 in_ready, out_valid, busy, sum, cout);
      end
    end
    rst = 1'b0; in_valid = 1'b0;
    $display("reset checked");
  endtask

  task automatic test_basic;
    int cyc;
    out_ready = 1'b1;
    accept_op(16'h1234, 16'h4321, 1'b0, 1'b0);
    total++;
    if (busy !== 1'b1 || in_ready !== 1'b0) begin
      bad++; $display("FAIL basic_run: busy=%b in_ready=%b required 1 0", busy, in_ready);
    end
    wait_done(cyc);
    total++;
    if (cyc != N || sum !== 16'h5555 || cout !== 1'b0) begin
      bad++; $display("FAIL basic: latency=%0d sum=%h cout=%b required %0d 5555 0", cyc, sum, cout, N);
    end
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL basic_release: in_ready=%b out_valid=%b busy=%b required 1 0 0", in_ready, out_valid, busy);
    end
    $display("op 1234+4321 cin=0 -> sum=%h cout=%b latency=%0d", sum, cout, cyc);
  endtask

  task automatic test_ripple;
    int cyc;
    out_ready = 1'b1;
    accept_op(16'hFFFF, 16'h0000, 1'b1, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != N || sum !== 16'h0000 || cout !== 1'b1) begin
      bad++; $display("FAIL ripple: latency=%0d sum=%h cout=%b required %0d 0000 1", cyc, sum, cout, N);
    end
    @(posedge clk); #1;
    $display("op ffff+0000 cin=1 -> sum=%h cout=%b", sum, cout);
  endtask

  task automatic test_stall;
    int cyc;
    logic [W-1:0] x, y;
    logic c;
    logic [W:0] exp;
    x = W'($urandom); y = W'($urandom); c = 1'($urandom);
    exp = model(x, y, c, 1'b0);
    out_ready = 1'b0;
    accept_op(x, y, c, 1'b0);
    wait_done(cyc);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0]; a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      total++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || {cout, sum} !== exp) begin
        bad++;
        $display("FAIL stall[%0d]: out_valid=%b in_ready=%b cout/sum=%h required 1 0 %h",
                 i, out_valid, in_ready, {cout, sum}, exp);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      bad++; $display("FAIL stall_release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    $display("op %h+%h cin=%b stalled 5 cycles -> %h", x, y, c, exp);
  endtask

  task automatic test_reset_mid;
    int cyc;
    out_ready = 1'b1;
    accept_op(16'hFFFF, 16'h0001, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    total++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || sum !== '0 || cout !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: in_ready=%b out_valid=%b busy=%b sum=%h cout=%b required 1 0 0 0000 0",
               in_ready, out_valid, busy, sum, cout);
    end
    accept_op(16'h0001, 16'h0001, 1'b0, 1'b0);
    wait_done(cyc);
    total++;
    if (cyc != N || sum !== 16'h0002 || cout !== 1'b0) begin
      bad++; $display("FAIL after_reset: latency=%0d sum=%h cout=%b required %0d 0002 0", cyc, sum, cout, N);
    end
    @(posedge clk); #1;
    $display("op 0001+0001 after mid-run reset -> sum=%h", sum);
  endtask

  task automatic test_back_to_back;
    logic [W:0] exp_q[$];
    int last_acc, cyc, n_res;
    logic [W:0] e;
    last_acc = -1; n_res = 0;
    in_valid = 1'b1; out_ready = 1'b1;
    for (cyc = 0; cyc < 40; cyc++) begin
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'b0;
      if (out_valid) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        n_res++;
        total++;
        if ({cout, sum} !== e) begin
          bad++; $display("FAIL b2b_result: cout/sum=%h required %h", {cout, sum}, e);
        end
        $display("b2b result %0d cout/sum=%h", n_res, {cout, sum});
      end
      if (in_ready) begin
        exp_q.push_back(model(a, b, cin, 1'b0));
        if (last_acc >= 0) begin
          total++;
          if (cyc - last_acc != N + 2) begin
            bad++; $display("FAIL b2b_spacing: gap=%0d required %0d", cyc - last_acc, N + 2);
          end
        end
        last_acc = cyc;
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    wait_done(cyc);
    @(posedge clk); #1;
    total++;
    if (n_res < 5) begin
      bad++; $display("FAIL b2b_count: results=%0d required >=5", n_res);
    end
  endtask

  task automatic test_random;
    int cyc;
    logic [W-1:0] x, y;
    logic c;
    logic [W:0] exp;
    for (int i = 0; i < 20; i++) begin
      x = W'($urandom); y = W'($urandom); c = 1'($urandom);
      if (i == 0) begin x = 16'hFFFF; y = 16'hFFFF; c = 1'b1; end
      exp = model(x, y, c, 1'b0);
      out_ready = 1'b0;
      accept_op(x, y, c, 1'b0);
      wait_done(cyc);
      repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
      total++;
      if (cyc != N || {cout, sum} !== exp) begin
        bad++; $display("FAIL random[%0d]: latency=%0d cout/sum=%h required %0d %h", i, cyc, {cout, sum}, N, exp);
      end
      $display("op %h+%h cin=%b -> cout/sum=%h", x, y, c, {cout, sum});
      out_ready = 1'b1;
      @(posedge clk); #1;
    end
  endtask

`ifdef NIBBLE_ADD_SEQ_SUB_EN
  task automatic test_sub;
    int cyc;
    logic [W-1:0] xs[3];
    logic [W-1:0] ys[3];
    logic [W:0] exp;
    xs[0] = 16'h0005; ys[0] = 16'h0007;
    xs[1] = 16'h0007; ys[1] = 16'h0005;
    xs[2] = W'($urandom); ys[2] = W'($urandom);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp = model(xs[i], ys[i], 1'b0, 1'b1);
      accept_op(xs[i], ys[i], 1'($urandom), 1'b1);
      wait_done(cyc);
      total++;
      if ({cout, sum} !== exp) begin
        bad++; $display("FAIL sub[%0d]: cout/sum=%h required %h", i, {cout, sum}, exp);
      end
      $display("op %h-%h -> cout/sum=%h", xs[i], ys[i], {cout, sum});
      @(posedge clk); #1;
    end
  endtask
`endif

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    test_reset;
    test_basic;
    test_ripple;
    test_stall;
    test_reset_mid;
    test_back_to_back;
    test_random;
`ifdef NIBBLE_ADD_SEQ_SUB_EN
    test_sub;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
